// File: rtl/coll_inject_arbiter.sv
// coll_inject_arbiter: round-robin, credit-limited arbiter sharing the router injection port
// among NUM_REQ requesters through a single registered output stage.
module coll_inject_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int PKT_W       = 72,
    parameter int MAX_CREDITS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*PKT_W-1:0] req_packet,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     out_valid,
    output logic [PKT_W-1:0]         out_packet,
    input  logic                     out_ready,
    input  logic                     done_in,
    output logic [2:0]               grant_id,
    output logic [3:0]               credit_cnt
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int SW = IW + 1;
    logic [IW-1:0]    rr_q, rr_d, win, grant_q;
    logic [SW-1:0]    idx;
    logic             found, can_load, grant, out_valid_q;
    logic [3:0]       credit_q, credit_d;
    logic [PKT_W-1:0] out_packet_q;
    assign can_load = (!out_valid_q || out_ready) && credit_q != 4'd0;
    // First valid requester at or after the rr pointer, wrapping past NUM_REQ-1.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = SW'(rr_q) + SW'(k);
            if (idx >= SW'(NUM_REQ)) idx = idx - SW'(NUM_REQ);
            if (!found && req_valid[idx[IW-1:0]]) begin
                found = 1'b1;
                win   = idx[IW-1:0];
            end
        end
    end
    assign req_ready = (!rst && can_load && found) ? NUM_REQ'(1) << win : '0;
    assign grant     = |(req_valid & req_ready);
    assign rr_d      = (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
    assign credit_d  = (grant && !done_in) ? credit_q - 4'd1 :
                       (!grant && done_in && credit_q != 4'(MAX_CREDITS)) ? credit_q + 4'd1 : credit_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_packet_q <= '0;
            grant_q      <= '0;
            rr_q         <= '0;
            credit_q     <= 4'(MAX_CREDITS);
        end else begin
            if (grant) begin
                out_packet_q <= req_packet[int'(win)*PKT_W +: PKT_W];
                grant_q      <= win;
                out_valid_q  <= 1'b1;
                rr_q         <= rr_d;
            end else if (out_ready) begin
                out_valid_q  <= 1'b0;
            end
            credit_q <= credit_d;
        end
    end
    assign out_valid  = out_valid_q;
    assign out_packet = out_packet_q;
    assign grant_id   = 3'(grant_q);
    assign credit_cnt = credit_q;
endmodule
